// File: rtl/shift_ctrl_4bit_if.sv
// Command handshake between a requester and the shift controller.
// The requester drives the command fields and cmd_valid; the controller
// answers with cmd_ready.
interface shift_ctrl_4bit_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       cmd_fill;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_cnt,
    output cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_cnt,
    input  cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_ctrl_4bit.sv
// Sequencer for a downstream 4-bit universal shift register.
// Accepts one command at a time (load / shift right / shift left / rotate
// right), drives the shifter strobes for the required number of cycles and
// pulses done once the operation has completed.
module shift_ctrl_4bit (
  input  logic                     clk,
  input  logic                     rst,
  shift_ctrl_4bit_if.slave         cmd,
  input  logic [3:0]               q_fb,
  output logic [3:0]               D,
  output logic                     D_sr,
  output logic                     D_sl,
  output logic                     ld,
  output logic                     sr,
  output logic                     sl,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic [1:0] op_q;
  logic [3:0] data_q;
  logic       fill_q;
  logic       accept;

  // Rotation only ever feeds back the LSB of the shifter.
  logic       q_fb_unused;
  assign q_fb_unused = ^q_fb[3:1];

  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // State register, command capture and shift-cycle down-counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      data_q  <= 4'h0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
        fill_q <= cmd.cmd_fill;
        cnt_q  <= cmd.cmd_cnt;
      end else if (state_q == ST_SHIFT) begin
        cnt_q  <= cnt_q - 3'd1;
      end
    end
  end

  // Next-state decode.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_LOAD)      state_d = ST_LOAD;
          else if (cmd.cmd_cnt != 3'd0)   state_d = ST_SHIFT;
          else                            state_d = ST_DONE;
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_q <= 3'd1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: strobes and data only in LOAD/SHIFT, everything quiet
  // while reset is held.
  always_comb begin
    cmd.cmd_ready = 1'b0;
    ld            = 1'b0;
    sr            = 1'b0;
    sl            = 1'b0;
    done          = 1'b0;
    D             = 4'h0;
    D_sr          = 1'b0;
    D_sl          = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: cmd.cmd_ready = 1'b1;
        ST_LOAD: begin
          ld = 1'b1;
          D  = data_q;
        end
        ST_SHIFT: begin
          unique case (op_q)
            OP_SHR: begin
              sr   = 1'b1;
              D_sr = fill_q;
            end
            OP_SHL: begin
              sl   = 1'b1;
              D_sl = fill_q;
            end
            OP_ROR: begin
              sr   = 1'b1;
              D_sr = q_fb[0];
            end
            default: ;
          endcase
        end
        ST_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_ctrl_4bit.md
SHIFT_CTRL_4BIT -- requirements
Module: shift_ctrl_4bit

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block can accept a command this cycle.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 load, 01 shift right, 10 shift left, 11 rotate right.
REQ-007 SHALL have port cmd_data, input, 4 bits: the load value (used by op 00 only).
REQ-008 SHALL have port cmd_cnt, input, 3 bits: number of shift cycles, 0..7 (ignored by op 00).
REQ-009 SHALL have port cmd_fill, input, 1 bit: the bit shifted in by ops 01 and 10.
REQ-010 SHALL have port q_fb, input, 4 bits: the current Q of the downstream 4-bit shift register.
REQ-011 SHALL have port D, output, 4 bits: the shifter data input.
REQ-012 SHALL have ports D_sr and D_sl, outputs, 1 bit each: the shifter MSB and LSB fill inputs.
REQ-013 SHALL have ports ld, sr and sl, outputs, 1 bit each: the shifter control strobes.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement a state machine with states IDLE, LOAD, SHIFT and DONE, held in a registered state variable.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-017 SHALL latch cmd_op, cmd_data, cmd_cnt and cmd_fill on acceptance; input changes while busy have no effect.
REQ-018 IDLE transitions on acceptance: op 00 -> LOAD; op 01/10/11 with cnt != 0 -> SHIFT; cnt == 0 -> DONE.
REQ-019 LOAD: ld = 1 and D = the latched data for exactly one cycle, then -> DONE.
REQ-020 SHIFT: a 3-bit down-counter is loaded with cnt; the state holds for exactly cnt consecutive cycles, then -> DONE.
REQ-021 SHIFT, op 01: sr = 1 and D_sr = the latched fill every SHIFT cycle.
REQ-022 SHIFT, op 10: sl = 1 and D_sl = the latched fill every SHIFT cycle.
REQ-023 SHIFT, op 11: sr = 1 and D_sr = q_fb[0] combinationally each cycle, so the downstream register rotates right.
REQ-024 DONE: done = 1 for exactly one cycle, all strobes 0, then -> IDLE; cmd_ready is 0 in DONE.
REQ-025 At most one of ld/sr/sl SHALL be 1 in any cycle.
REQ-026 All strobes SHALL be 0 outside LOAD and SHIFT.
REQ-027 D, D_sr and D_sl SHALL be 0 whenever they are not in use.
REQ-028 Latency: the first strobe is in the cycle after acceptance; done is asserted in the cycle after the last strobe.
REQ-029 Minimum command spacing SHALL be: load 3 cycles, shift cnt+2 cycles, cnt==0 2 cycles.
REQ-030 cmd_valid held high back-to-back SHALL result in a new command being accepted on the first IDLE cycle after DONE.

Reset
REQ-031 rst = 1 at a rising edge SHALL force state IDLE, counter 0 and latched command fields 0, with priority over everything else.
REQ-032 During and after reset, the outputs SHALL be: cmd_ready = 1 (after reset release, in IDLE), ld = sr = sl = 0, D = 0, D_sr = D_sl = 0, done = 0.
REQ-033 Reset during LOAD or SHIFT SHALL abort immediately: no further strobes and no done pulse.
REQ-034 A command presented in the same cycle as rst = 1 SHALL NOT be accepted.

Verification
REQ-035 Load: op=00, data=4'b1011 accepted at cycle t -> ld=1 and D=1011 at t+1; done at t+2; shifter Q=1011.
REQ-036 Shift right: Q=1011, op=01, cnt=2, fill=0 -> sr high for t+1..t+2; done at t+3; Q=0010.
REQ-037 Shift left: Q=0001, op=10, cnt=3, fill=1 -> sl high for 3 cycles; Q=1111; no ld or sr ever.
REQ-038 Rotate right: Q=1000, op=11, cnt=4 -> Q=1000 again after 4 cycles; with cnt=1 -> Q=0100.
REQ-039 Boundaries: cnt=0 -> no strobe, done at t+1. cnt=7 -> exactly 7 strobes. Back-to-back valid -> accepts on cycles 0, 3 and 6 for three loads.
REQ-040 Reset mid-operation: rst asserted at the 2nd SHIFT cycle of cnt=5 -> strobes 0 the next cycle, no done, cmd_ready=1 after release.
